// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: round-robin arbiter and command sequencer for a bank of
// WIDTH JK flip-flops. One command at a time drives J/K for cnt clock edges,
// then a one-cycle done pulse reports which requester finished.
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] mask0,
  input  logic [CW-1:0]    cnt0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] mask1,
  input  logic [CW-1:0]    cnt1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // last_id is the requester served most recently; the other one wins a tie
  logic             last_id;
  logic             cur_id;
  logic [1:0]       cur_op;
  logic [WIDTH-1:0] cur_mask;
  logic [CW-1:0]    remain;

  logic             win_id;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_mask;
  logic [CW-1:0]    win_cnt;
  logic             take;

  // Pick the winner and mux its command fields
  always_comb begin
    win_id   = (req == 2'b11) ? ~last_id : req[1];
    win_op   = win_id ? op1   : op0;
    win_mask = win_id ? mask1 : mask0;
    win_cnt  = win_id ? cnt1  : cnt0;
    take     = (state == IDLE) && (req != 2'b00);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a zero count skips APPLY entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nxt = (win_cnt == '0) ? DONE : APPLY;
        end
      end
      APPLY: begin
        if (remain <= CW'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Status and J/K decode; J/K are only driven while applying
  always_comb begin
    j_vec   = '0;
    k_vec   = '0;
    busy    = (state != IDLE);
    done    = (state == DONE);
    done_id = (state == DONE) ? cur_id : 1'b0;
    if (state == APPLY) begin
      j_vec = cur_op[1] ? cur_mask : '0;
      k_vec = cur_op[0] ? cur_mask : '0;
    end
  end

  // Grant, command latch, counter and the JK bank itself
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt      <= 2'b00;
      last_id  <= 1'b1;
      cur_id   <= 1'b0;
      cur_op   <= 2'b00;
      cur_mask <= '0;
      remain   <= '0;
      q        <= '0;
    end else begin
      gnt <= 2'b00;
      if (take) begin
        gnt      <= win_id ? 2'b10 : 2'b01;
        last_id  <= win_id;
        cur_id   <= win_id;
        cur_op   <= win_op;
        cur_mask <= win_mask;
        remain   <= win_cnt;
      end
      if (state == APPLY) begin
        q      <= (j_vec & ~q) | (~k_vec & q);
        remain <= remain - CW'(1);
      end
    end
  end

  assign qb = ~q;

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
Command sequencer and two-port arbiter for a WIDTH-bit bank of JK flip-flops that the block owns. Two requesters each submit a command: an operation (hold/clear/set/toggle), a bit mask and a repeat count. The block arbitrates round-robin, drives the bank's J/K vectors for the requested number of clock edges, then reports completion. It sits between control logic and the JK register bank and serialises all access to it.

Parameters:
WIDTH, 4, number of JK flip-flops in the bank
CW, 4, width of the repeat-count field

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
req  in  2  request, one bit per requester; held high until the matching gnt bit
op0  in  2  requester 0 operation: 00 hold, 01 clear, 10 set, 11 toggle
mask0  in  WIDTH  requester 0 bit mask
cnt0  in  CW  requester 0 repeat count (clock edges)
op1  in  2  requester 1 operation
mask1  in  WIDTH  requester 1 bit mask
cnt1  in  CW  requester 1 repeat count
gnt  out  2  one-hot grant, high for exactly one cycle per command
busy  out  1  high while a command is in progress (APPLY or DONE)
done  out  1  one-cycle completion pulse
done_id  out  1  requester index of the completed command; valid while done=1
j_vec  out  WIDTH  J inputs currently applied to the bank
k_vec  out  WIDTH  K inputs currently applied to the bank
q  out  WIDTH  bank state
qb  out  WIDTH  bitwise complement of q

Behaviour:
- Reset (rst=0, asynchronous; takes effect immediately, including mid-command):
  - state IDLE; q=0, qb=all ones; j_vec=k_vec=gnt=0; busy=done=done_id=0.
  - round-robin pointer set so requester 0 wins the first tie.
- FSM states: IDLE, APPLY, DONE.
- IDLE:
  - On a clock edge with any req bit high: select the winner, latch its op/mask/cnt and the winner id, load the remaining counter with cnt, and go to APPLY.
  - Winner selection: with a single requester, that requester wins. With both high, the requester not served last wins.
  - The pointer updates on each grant.
  - If cnt=0, go directly to DONE; q is untouched.
- gnt is registered. The winner's bit is high for the first cycle after the grant edge only.
- APPLY:
  - j_vec/k_vec are decoded from the latched op and mask: hold j=0,k=0; clear j=0,k=mask; set j=mask,k=0; toggle j=mask,k=mask.
  - On every edge in APPLY, each bit updates as q <= (j & ~q) | (~k & q), and the remaining counter decrements.
  - The edge that takes the counter from 1 to 0 performs the last update and moves to DONE.
  - A command therefore applies exactly cnt updates; the maximum is 2^CW-1.
- DONE:
  - j_vec=k_vec=0; done=1 and done_id=latched id for one cycle; busy=1.
  - The next edge returns to IDLE.
  - Arbitration resumes on the following edge; there is no back-to-back grant from DONE.
- req changes during APPLY/DONE are ignored. The latched command is immutable until DONE.
- qb is always the bitwise complement of q, with no extra latency.
- Bits outside mask keep their value for every op.

Test Plan:
- Reset: drive rst=0 with random inputs -> q=0000, qb=1111, gnt=00, busy=0, done=0. Assert rst=0 mid-APPLY -> q=0000 immediately, no done pulse.
- Set: from q=0000, req0 with op0=10, mask0=0101, cnt0=1 -> gnt=01 for one cycle; q=0101 after one APPLY edge; done=1, done_id=0 on the next cycle.
- Toggle: from q=0101, req1 with op1=11, mask1=1111, cnt1=3 -> q goes 1010, 0101, 1010; final q=1010; done_id=1. Clear with mask=1000 then gives q=0010.
- Arbitration: both req high from reset, each with cnt=1 -> grant order is 0, then 1. With both held for four commands -> order 0,1,0,1; gnt is never 11.
- Zero count: req0 with op0=11, mask0=1111, cnt0=0 -> gnt, then done pulse; q unchanged; j_vec/k_vec stay 0.
- Hold and mask: op=00 with cnt=5 -> q unchanged; busy high for 6 cycles (5 APPLY + 1 DONE).
